shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits, matching the codebase's 8-bit single-position shift cell (regdec).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a new multi-position shift; sampled only when ready=1.
REQ-005 dir  input  1  direction: 1 = left (toward MSB, LSB zero-filled), 0 = right (toward LSB, MSB zero-filled).
REQ-006 amount  input  4  requested shift count, 0..15.
REQ-007 data_in  input  8  operand, captured with start.
REQ-008 ready  output  1  high in IDLE and DONE; start is accepted only while ready=1.
REQ-009 busy  output  1  high in SHIFT.
REQ-010 done  output  1  single-cycle completion strobe, high in DONE.
REQ-011 data_out  output  8  working/result register; holds its value until the next accepted start or reset.

Function
REQ-012 Datapath SHALL be one instance of regdec (a = data_out, rl = latched dir); the next working-register value comes only from its s output or from data_in on load.
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE, with ready = (state != SHIFT), busy = (state == SHIFT) and done = (state == DONE), all decoded from registered state.
REQ-014 Effective count SHALL be min(amount, 8), held in a 4-bit down-counter cnt.
REQ-015 On an edge with ready=1 and start=1 (accept edge k):
- data_out <= data_in;
- dir is latched;
- cnt <= effective count;
- next state = DONE if the count is 0, else SHIFT.
REQ-016 On each edge in SHIFT:
- data_out <= regdec output;
- cnt <= cnt-1;
- when cnt==1, next state = DONE; otherwise stay in SHIFT.
REQ-017 Timing for an effective count N: done SHALL be high exactly in the cycle following edge k+N, and data_out in that cycle SHALL equal data_in shifted N places with zero fill.
REQ-018 On an edge in DONE with start=0, the next state SHALL be IDLE; on an edge in DONE with start=1, a new operation SHALL be accepted per REQ-015 (back-to-back, no idle cycle).
REQ-019 start and changes to dir, amount or data_in while in SHIFT SHALL be ignored, with no effect on the current operation.
REQ-020 In IDLE with start=0, all registers SHALL hold.
REQ-021 No illegal state SHALL persist: any unencoded state value SHALL go to IDLE on the next edge.

Reset
REQ-022 When reset=1 on an edge, regardless of state or start, the block SHALL set state=IDLE, cnt=0, data_out=0x00 and latched dir=0, giving ready=1, busy=0 and done=0 in the following cycle.
REQ-023 Reset SHALL take priority over start on the same edge.
REQ-024 Reset during SHIFT SHALL abort the operation with no done pulse.

Verification
REQ-025 data_in=0x81, dir=1, amount=3 at edge k -> busy high for 3 cycles; done high after edge k+3; data_out=0x08.
REQ-026 data_in=0x81, dir=0, amount=1 -> done after edge k+1; data_out=0x40.
REQ-027 data_in=0xA5, amount=0 -> no busy cycle; done after edge k; data_out=0xA5.
REQ-028 data_in=0xFF, dir=1, amount=12 -> exactly 8 busy cycles; done after edge k+8; data_out=0x00.
REQ-029 Second start with data_in=0x01, dir=1, amount=2 asserted in the DONE cycle of a prior operation -> accepted; done after 2 further edges; data_out=0x04. A start asserted mid-SHIFT -> ignored, and the original result is unchanged.
REQ-030 reset=1 at the 2nd SHIFT edge of a dir=1, amount=5 operation -> next cycle shows data_out=0x00, ready=1, busy=0, and no done pulse at any later cycle until a new start is accepted.

Source files
------------

// File: rtl/shift_seq.sv
// Multi-position shifter: a sequencer that drives one single-position shift cell
// (regdec) over up to 8 cycles, with IDLE/SHIFT/DONE handshake outputs.

module regdec (
  input  logic [7:0] a,
  input  logic       rl,
  output logic [7:0] s
);

  // One-place shift with zero fill; rl=1 moves toward the MSB.
  always_comb begin
    s = 8'h00;
    if (rl) begin
      s = {a[6:0], 1'b0};
    end else begin
      s = {1'b0, a[7:1]};
    end
  end

endmodule

module shift_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic [3:0] amount,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t     state_r;
  logic [3:0] cnt_r;
  logic       dir_r;
  logic [7:0] shift_s;
  logic [3:0] eff_s;

  // Shifting more than the word width gives all zeros, so cap the count at 8.
  function automatic logic [3:0] eff_count(input logic [3:0] amt);
    logic [3:0] res;
    if (amt > 4'd8) begin
      res = 4'd8;
    end else begin
      res = amt;
    end
    return res;
  endfunction

  regdec u_regdec (
    .a  (data_out),
    .rl (dir_r),
    .s  (shift_s)
  );

  // Effective shift count for the operand presented this cycle.
  always_comb begin
    eff_s = 4'd0;
    eff_s = eff_count(amount);
  end

  // Sequencer: state, counter, latched direction, working register and
  // handshake flags, all updated together so the flags track the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      dir_r    <= 1'b0;
      data_out <= 8'h00;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            data_out <= data_in;
            dir_r    <= dir;
            cnt_r    <= eff_s;
            if (eff_s == 4'd0) begin
              state_r <= ST_DONE;
              ready   <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= ST_SHIFT;
              ready   <= 1'b0;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          data_out <= shift_s;
          cnt_r    <= cnt_r - 4'd1;
          // A zero count here is unreachable; finishing on it avoids a 16-cycle wrap.
          if (cnt_r <= 4'd1) begin
            state_r <= ST_DONE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
            ready   <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: accepted operations queue their expected
// result and completion edge; a negedge monitor checks handshake and data.

module tb_shift_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic       dir;
  logic [3:0] amount;
  logic [7:0] data_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  typedef struct {
    logic [7:0] data;
    int         acc_edge;
    int         done_edge;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  bit   mon_en   = 1'b0;

  shift_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dir      (dir),
    .amount   (amount),
    .data_in  (data_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [7:0] shift_model(input logic [7:0] din, input logic d,
                                             input logic [3:0] amt);
    logic [7:0] r;
    int n;
    r = din;
    n = (amt > 4'd8) ? 8 : int'(amt);
    for (int i = 0; i < n; i++) r = d ? (r << 1) : (r >> 1);
    return r;
  endfunction

  // Monitor: expectations come only from the queue front and the edge count.
  always @(negedge clk) begin
    logic busy_exp;
    logic done_exp;
    if (mon_en && !reset) begin
      busy_exp = 1'b0;
      done_exp = 1'b0;
      if (sb.size() > 0) begin
        if (edge_cnt >= sb[0].acc_edge && edge_cnt < sb[0].done_edge) busy_exp = 1'b1;
        if (edge_cnt == sb[0].done_edge) done_exp = 1'b1;
      end
      check_eq("busy", {7'd0, busy}, {7'd0, busy_exp});
      check_eq("ready", {7'd0, ready}, {7'd0, !busy_exp});
      check_eq("done", {7'd0, done}, {7'd0, done_exp});
      if (sb.size() > 0 && edge_cnt >= sb[0].done_edge) begin
        if (done_exp) check_eq("result", data_out, sb[0].data);
        void'(sb.pop_front());
      end
    end
  end

  task automatic next_cyc();
    @(negedge clk);
    #2;
  endtask

  // Drives one accepted start and queues its expected outcome.
  task automatic start_op(input logic [7:0] din, input logic d, input logic [3:0] amt,
                          input logic [7:0] exp);
    exp_t e;
    int n;
    n = (amt > 4'd8) ? 8 : int'(amt);
    start   = 1'b1;
    data_in = din;
    dir     = d;
    amount  = amt;
    e.data      = exp;
    e.acc_edge  = edge_cnt + 1;
    e.done_edge = edge_cnt + 1 + n;
    sb.push_back(e);
    next_cyc();
    start   = 1'b0;
    data_in = 8'($urandom);
    dir     = 1'($urandom);
    amount  = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      next_cyc();
      n++;
    end
    check_eq("drain", 8'(sb.size()), 8'd0);
    sb.delete();
  endtask

  task automatic run_op(input logic [7:0] din, input logic d, input logic [3:0] amt,
                        input logic [7:0] exp);
    start_op(din, d, amt, exp);
    wait_idle();
    repeat (3) next_cyc();
    check_eq("hold", data_out, exp);
  endtask

  initial begin
    int acc;
    int n;
    logic [7:0] rd;
    logic [3:0] ra;
    logic       rdir;

    reset   = 1'b1;
    start   = 1'b1;
    dir     = 1'b0;
    amount  = 4'd0;
    data_in = 8'h00;
    next_cyc();
    next_cyc();
    check_eq("rst_data", data_out, 8'h00);
    check_eq("rst_ready", {7'd0, ready}, 8'd1);
    check_eq("rst_busy", {7'd0, busy}, 8'd0);
    check_eq("rst_done", {7'd0, done}, 8'd0);
    start  = 1'b0;
    reset  = 1'b0;
    mon_en = 1'b1;
    next_cyc();

    run_op(8'h81, 1'b1, 4'd3, 8'h08);
    run_op(8'h81, 1'b0, 4'd1, 8'h40);
    run_op(8'hA5, 1'b1, 4'd0, 8'hA5);
    run_op(8'hFF, 1'b1, 4'd12, 8'h00);

    // Back-to-back: second start lands in the DONE cycle of the first.
    start_op(8'h3C, 1'b0, 4'd2, 8'h0F);
    acc = edge_cnt;
    n = 0;
    while (edge_cnt != acc + 2 && n < 20) begin
      next_cyc();
      n++;
    end
    check_eq("b2b_in_done", {7'd0, done}, 8'd1);
    start_op(8'h01, 1'b1, 4'd2, 8'h04);
    wait_idle();
    check_eq("b2b_result", data_out, 8'h04);

    // Start and operand changes mid-SHIFT must be ignored.
    start_op(8'h81, 1'b1, 4'd5, 8'h20);
    next_cyc();
    start   = 1'b1;
    data_in = 8'hFF;
    amount  = 4'd1;
    dir     = 1'b0;
    next_cyc();
    start   = 1'b0;
    wait_idle();
    repeat (2) next_cyc();
    check_eq("ignore_hold", data_out, 8'h20);

    // Reset at the second SHIFT edge aborts with no done pulse.
    start_op(8'h81, 1'b1, 4'd5, 8'h20);
    next_cyc();
    reset = 1'b1;
    sb.delete();
    next_cyc();
    check_eq("abort_data", data_out, 8'h00);
    check_eq("abort_ready", {7'd0, ready}, 8'd1);
    check_eq("abort_busy", {7'd0, busy}, 8'd0);
    check_eq("abort_done", {7'd0, done}, 8'd0);
    reset = 1'b0;
    repeat (12) next_cyc();

    for (int i = 0; i < 8; i++) begin
      rd   = 8'($urandom_range(255, 0));
      ra   = 4'($urandom_range(15, 0));
      rdir = 1'($urandom_range(1, 0));
      run_op(rd, rdir, ra, shift_model(rd, rdir, ra));
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
